smac_result_drain: RTL and testbench
====================================

Name: smac_result_drain

Overview:
- Downstream collector for one smac column. Tracks every operand issue through the smac chain latency, then captures the column output `res_mac_n` when it becomes valid.
- Captured results are buffered in a small FIFO. They leave on an AXI-Stream-style master port toward the output DMA, with `tlast` framing every BURST_LEN beats.
- Supports back-to-back issues (pipelined tracking), `ce` stalls and narrow (32-bit precision) masking.

Parameters:
- DATA_W, 64, width of `res_mac_n` and `m_tdata`.
- LATENCY, 10, smac chain latency in `ce`-enabled cycles from issue to valid result; legal range 1..63.
- DEPTH, 8, FIFO entries; power of two, ≥2.
- BURST_LEN, 16, beats per `tlast` frame; ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- aresetn  in  1  asynchronous active-low reset.
- ce  in  1  same enable driven to the smac chain; low freezes issue tracking.
- issue  in  1  an operand set enters the chain this cycle; ignored when `ce`=0.
- narrow  in  1  1 = 32-bit precision active; upper DATA_W-32 bits of captured data forced to 0.
- res_mac_n  in  DATA_W  smac column result.
- m_tdata  out  DATA_W  FIFO head data.
- m_tvalid  out  1  FIFO non-empty.
- m_tready  in  1  consumer ready.
- m_tlast  out  1  head beat is last of the current BURST_LEN frame.
- count  out  clog2(DEPTH+1)  FIFO occupancy.
- busy  out  1  issue in flight or FIFO non-empty.
- overflow  out  1  sticky: a result was dropped.
- clear_ovf  in  1  synchronous clear of `overflow`.

Behaviour:
- Reset (`aresetn`=0, async): delay line, FIFO pointers, `count`, beat counter and `overflow` go to 0. `m_tdata`=0, `m_tvalid`=0, `m_tlast`=0, `busy`=0. Reset mid-operation discards all in-flight issues and buffered data; no beat appears after release until a new issue completes.
- Issue tracking: LATENCY-bit shift register.
  - Shifts only on edges where `ce`=1; stage 0 loads `issue`.
  - When `ce`=0 the register holds, and `issue` is ignored.
  - Capture strobe = last stage set AND `ce`=1.
  - Net effect: an issue accepted at `ce`-edge k is captured at `ce`-edge k+LATENCY. `ce`-low cycles in between add no latency count.
- Capture:
  - Data written is `res_mac_n` sampled at the capture edge.
  - If `narrow`=1 at that edge, bits [DATA_W-1:32] are written as 0.
  - Back-to-back issues produce back-to-back captures, one per cycle.
- FIFO: synchronous, DEPTH entries.
  - Push = capture strobe AND (not full OR pop this cycle).
  - Pop = `m_tvalid` AND `m_tready`.
  - Simultaneous push and pop when full: both happen; `count` is unchanged.
  - Simultaneous push and pop when empty: the push is stored and the pop is impossible (`m_tvalid`=0). No fall-through; a stored entry is visible on `m_tdata` the cycle after its push.
  - Pointers wrap modulo DEPTH.
  - `m_tdata` and `m_tvalid` are stable while `m_tvalid`=1 and `m_tready`=0.
- Overflow:
  - A capture strobe while full with no pop drops the sample and sets `overflow` on that edge.
  - `overflow` holds until `clear_ovf`=1.
  - Set and clear in the same cycle: set wins.
- Framing:
  - Beat counter 0..BURST_LEN-1 increments on each pop and wraps to 0 after BURST_LEN-1.
  - `m_tlast` = `m_tvalid` AND (counter == BURST_LEN-1).
  - Dropped samples do not advance the counter.
- `busy` = OR of all delay-line bits OR (`count` ≠ 0). It is combinational from registers.
- `count`, `m_tvalid` and `m_tlast` update on the edge of push/pop.

Test Plan:
- Single issue: LATENCY=10, `ce`=1, `issue` at edge 0, `res_mac_n`=64'h0000_0000_CAFE_CAFF valid at edge 10, `m_tready`=1. Required: `m_tvalid`=1 after edge 10 with that data; `busy` drops after the pop.
- `ce` stall: issue at edge 0, `ce`=0 for 3 cycles mid-flight. Required: capture at absolute edge 13; an `issue` pulse during `ce`=0 produces no beat.
- Narrow mask: `narrow`=1, `res_mac_n`=64'hDEAD_BEEF_1234_5678. Required: `m_tdata`=64'h0000_0000_1234_5678; with `narrow`=0 the full value is passed.
- Burst framing: BURST_LEN=4, issue 8 consecutive cycles, `m_tready`=1. Required: 8 beats in order, `m_tlast` on beats 4 and 8 only.
- Backpressure/overflow: DEPTH=8, `m_tready`=0, issue 10 consecutive cycles. Required: `count`=8, `overflow`=1 at the 9th capture. Then `m_tready`=1: exactly the first 8 values drain in order. `clear_ovf` asserted together with a new overflow event leaves `overflow`=1.
- Async reset: deassert `aresetn` with 3 issues in flight and 2 entries buffered. Required: outputs 0 immediately, not at the clock edge; after release, no beats until a new issue.

Source files
------------

// File: rtl/smac_result_drain.sv
// smac_result_drain: tracks smac issues through the chain latency, captures column results
// into a small FIFO and drains them as an AXI-Stream burst with tlast framing.
module smac_result_drain #(
    parameter int DATA_W    = 64,
    parameter int LATENCY   = 10,
    parameter int DEPTH     = 8,
    parameter int BURST_LEN = 16
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic                         ce,
    input  logic                         issue,
    input  logic                         narrow,
    input  logic [DATA_W-1:0]            res_mac_n,
    output logic [DATA_W-1:0]            m_tdata,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic                         m_tlast,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy,
    output logic                         overflow,
    input  logic                         clear_ovf
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
    localparam logic [DATA_W-1:0] LO_MASK = DATA_W'({32{1'b1}});
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    logic [LATENCY-1:0] dly;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [AW-1:0]      rd_ptr, wr_ptr;
    logic [BW-1:0]      beat;
    logic               cap, full, pop, push;

    assign cap      = dly[LATENCY-1] & ce;
    assign full     = count == CW'(DEPTH);
    assign m_tvalid = count != '0;
    assign pop      = m_tvalid & m_tready;
    assign push     = cap & (~full | pop);
    assign m_tdata  = m_tvalid ? mem[rd_ptr] : '0;
    assign m_tlast  = m_tvalid & (beat == LAST_BEAT);
    assign busy     = |dly | m_tvalid;

    always_ff @(posedge clk or negedge aresetn)
        if (!aresetn) begin
            dly      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            beat     <= '0;
            overflow <= 1'b0;
        end else begin
            if (ce) dly <= LATENCY'({dly, issue});
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (pop) beat <= beat == LAST_BEAT ? '0 : beat + BW'(1);
            count    <= count + CW'(push) - CW'(pop);
            overflow <= (cap & full & ~pop) | (overflow & ~clear_ovf);
        end

    // Storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= narrow ? res_mac_n & LO_MASK : res_mac_n;
endmodule

// File: tb/tb_smac_result_drain.sv
// tb_smac_result_drain: randomized and directed checks of smac_result_drain against a queue-based model.
module tb_smac_result_drain;
    localparam int DATA_W = 64, LAT = 10, DEPTH = 8, BL = 4;

    logic              clk = 1'b0;
    logic              aresetn, ce, issue, narrow, m_tready, clear_ovf;
    logic [DATA_W-1:0] res_mac_n, m_tdata;
    logic              m_tvalid, m_tlast, busy, overflow;
    logic [3:0]        count;

    int                n_tests = 0, n_fail = 0;
    int                tq[$];
    logic [63:0]       fq[$];
    int                ce_cnt = 0, beat = 0;
    bit                ovf = 0;

    smac_result_drain #(.DATA_W(DATA_W), .LATENCY(LAT), .DEPTH(DEPTH), .BURST_LEN(BL)) dut (
        .clk(clk), .aresetn(aresetn), .ce(ce), .issue(issue), .narrow(narrow),
        .res_mac_n(res_mac_n), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .count(count), .busy(busy), .overflow(overflow), .clear_ovf(clear_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        chk("tvalid", 64'(m_tvalid), 64'(fq.size() > 0));
        chk("tdata", m_tdata, fq.size() > 0 ? fq[0] : 64'd0);
        chk("tlast", 64'(m_tlast), 64'(fq.size() > 0 && beat == BL - 1));
        chk("count", 64'(count), 64'(fq.size()));
        chk("busy", 64'(busy), 64'(tq.size() > 0 || fq.size() > 0));
        chk("overflow", 64'(overflow), 64'(ovf));
    endtask

    // One clock: apply inputs, advance the model by the same edge, compare just after it.
    task automatic step(input bit c, input bit i, input bit n, input logic [63:0] r,
                        input bit t, input bit cl);
        bit pop, full, cap;
        ce = c; issue = i; narrow = n; res_mac_n = r; m_tready = t; clear_ovf = cl;
        @(posedge clk);
        pop  = fq.size() > 0 && t;
        full = fq.size() == DEPTH;
        cap  = 0;
        if (c) begin
            ce_cnt++;
            if (tq.size() > 0 && tq[0] == ce_cnt) begin
                cap = 1;
                void'(tq.pop_front());
            end
            if (i) tq.push_back(ce_cnt + LAT);
        end
        if (pop) begin
            void'(fq.pop_front());
            beat = (beat + 1) % BL;
        end
        if (cap && (!full || pop)) fq.push_back(n ? {32'h0, r[31:0]} : r);
        ovf = (cap && full && !pop) || (ovf && !cl);
        #1 check_model();
    endtask

    task automatic do_reset();
        #3 aresetn = 1'b0;
        #1;
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tdata", m_tdata, 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tlast", 64'(m_tlast), 64'd0);
        tq.delete();
        fq.delete();
        beat = 0;
        ovf = 0;
        #1 aresetn = 1'b1;
    endtask

    initial begin
        aresetn = 1'b0; ce = 0; issue = 0; narrow = 0; res_mac_n = '0; m_tready = 0; clear_ovf = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_tvalid", 64'(m_tvalid), 64'd0);
        chk("init_busy", 64'(busy), 64'd0);
        chk("init_overflow", 64'(overflow), 64'd0);
        chk("init_count", 64'(count), 64'd0);
        aresetn = 1'b1;

        // single issue
        step(1, 1, 0, 64'hCAFECAFF, 1, 0);
        repeat (10) step(1, 0, 0, 64'hCAFECAFF, 1, 0);
        chk("single_valid", 64'(m_tvalid), 64'd1);
        chk("single_data", m_tdata, 64'h0000_0000_CAFE_CAFF);
        step(1, 0, 0, 64'h0, 1, 0);
        chk("single_busy", 64'(busy), 64'd0);

        // ce stall with ignored issue pulses
        step(1, 1, 0, 64'h5151, 1, 0);
        repeat (4) step(1, 0, 0, 64'h5151, 1, 0);
        repeat (3) step(0, 1, 0, 64'h5151, 1, 0);
        repeat (5) step(1, 0, 0, 64'h5151, 1, 0);
        chk("stall_early", 64'(m_tvalid), 64'd0);
        step(1, 0, 0, 64'h5151, 1, 0);
        chk("stall_capture", 64'(m_tvalid), 64'd1);
        repeat (15) step(1, 0, 0, 64'h0, 1, 0);

        // narrow masking
        step(1, 1, 1, 64'hDEADBEEF12345678, 0, 0);
        repeat (10) step(1, 0, 1, 64'hDEADBEEF12345678, 0, 0);
        chk("narrow_data", m_tdata, 64'h0000_0000_1234_5678);
        step(1, 1, 0, 64'hDEADBEEF12345678, 1, 0);
        repeat (10) step(1, 0, 0, 64'hDEADBEEF12345678, 0, 0);
        chk("wide_data", m_tdata, 64'hDEADBEEF12345678);
        step(1, 0, 0, 64'h0, 1, 0);

        // burst framing
        for (int j = 0; j < 22; j++) step(1, j < 8, 0, 64'h1000 + 64'(j), 1, 0);

        // backpressure and overflow
        for (int j = 0; j < 20; j++) step(1, j < 10, 0, 64'h2000 + 64'(j), 0, 0);
        chk("ovf_count", 64'(count), 64'd8);
        chk("ovf_set", 64'(overflow), 64'd1);
        repeat (10) step(1, 0, 0, 64'h0, 1, 0);
        step(1, 0, 0, 64'h0, 1, 1);
        for (int j = 0; j < 20; j++) begin
            step(1, j < 9, 0, 64'h3000 + 64'(j), 0, j == 18);
            if (j == 18) chk("ovf_set_wins", 64'(overflow), 64'd1);
        end
        repeat (10) step(1, 0, 0, 64'h0, 1, 1);

        // async reset with work in flight and buffered
        for (int j = 0; j < 12; j++) step(1, j < 2 || (j >= 8 && j <= 10), 0, 64'h4000 + 64'(j), 0, 0);
        chk("pre_rst_count", 64'(count), 64'd2);
        do_reset();
        repeat (15) step(1, 0, 0, 64'h0, 1, 0);

        // randomized traffic with varying backpressure
        for (int p = 0; p < 3; p++)
            repeat (600) step($urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(1) == 1,
                              {$urandom, $urandom}, $urandom_range(3) <= p, $urandom_range(15) == 0);
        repeat (40) step(1, 0, 0, 64'h0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
